vc_allocator: RTL and testbench

VC_ALLOCATOR -- requirements
Module: vc_allocator

---
 rtl/params_noc.sv | 20 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/vc_allocator.sv | 120 ++++++++++++
 tb/tb_vc_allocator.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/params_noc.sv
// rtl/params_noc.sv - NoC-wide parameters, port encodings and VC state type
package params_noc;

  localparam int PORT_NUM   = 5;
  localparam int VC_NUM     = 2;
  localparam int VC_Size    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int inout_Port = 3;

  localparam logic [inout_Port-1:0] LOCAL = 3'd0;
  localparam logic [inout_Port-1:0] NORTH = 3'd1;
  localparam logic [inout_Port-1:0] EAST  = 3'd2;
  localparam logic [inout_Port-1:0] SOUTH = 3'd3;
  localparam logic [inout_Port-1:0] WEST  = 3'd4;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } vc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves past winner on grant
module rr_arbiter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            win;
  int            idx;

  // Scan from the highest offset down so the last hit is the one closest to the pointer.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (en_i && found) begin
      gnt_o[win] = 1'b1;
      ptr_d      = PW'((win + 1) % N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vc_allocator.sv
// rtl/vc_allocator.sv - per-output-port VC allocator; error checking under VC_ALLOC_ERR_CHECK_EN
module vc_allocator
  import params_noc::*;
#(
  parameter int NUM_IN = PORT_NUM * VC_NUM
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN-1:0]              vc_req_i,
  input  logic [NUM_IN*inout_Port-1:0]   port_req_i,
  input  logic [PORT_NUM*VC_NUM-1:0]     vc_release_i,
  output logic [NUM_IN-1:0]              vc_val_o,
  output logic [NUM_IN*VC_Size-1:0]      vc_new_o,
  output logic [PORT_NUM*VC_NUM-1:0]     vc_busy_o,
  output logic                           err_o
);

  localparam int NVC = PORT_NUM * VC_NUM;

  vc_state_t                state_q [NVC];
  vc_state_t                state_d [NVC];
  logic [NUM_IN-1:0]        vc_val_q, vc_val_d;
  logic [NUM_IN*VC_Size-1:0] vc_new_q, vc_new_d;

  logic [NUM_IN-1:0]        port_req_vec  [PORT_NUM];
  logic [NUM_IN-1:0]        port_gnt      [PORT_NUM];
  logic [PORT_NUM-1:0]      port_has_free;
  logic [VC_Size-1:0]       port_free_idx [PORT_NUM];

  // Requesters already showing a grant pulse sit out so a held request cannot win twice.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      port_req_vec[p]  = '0;
      port_has_free[p] = 1'b0;
      port_free_idx[p] = '0;
      for (int r = 0; r < NUM_IN; r++) begin
        port_req_vec[p][r] = vc_req_i[r] && !vc_val_q[r] &&
                             (port_req_i[r*inout_Port +: inout_Port] == inout_Port'(p));
      end
      for (int v = VC_NUM - 1; v >= 0; v--) begin
        if (state_q[p*VC_NUM + v] == FREE) begin
          port_has_free[p] = 1'b1;
          port_free_idx[p] = VC_Size'(v);
        end
      end
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    rr_arbiter #(.N(NUM_IN)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (port_req_vec[p]),
      .en_i  (port_has_free[p]),
      .gnt_o (port_gnt[p])
    );
  end

  // Releases only clear BUSY VCs and grants only take FREE ones, so the two never collide.
  always_comb begin
    vc_val_d = '0;
    vc_new_d = vc_new_q;
    for (int v = 0; v < NVC; v++) begin
      state_d[v] = state_q[v];
      if (vc_release_i[v]) state_d[v] = FREE;
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int r = 0; r < NUM_IN; r++) begin
        if (port_gnt[p][r]) begin
          vc_val_d[r]                      = 1'b1;
          vc_new_d[r*VC_Size +: VC_Size]   = port_free_idx[p];
          state_d[p*VC_NUM + int'(port_free_idx[p])] = BUSY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_val_q <= '0;
      vc_new_q <= '0;
      for (int v = 0; v < NVC; v++) state_q[v] <= FREE;
    end else begin
      vc_val_q <= vc_val_d;
      vc_new_q <= vc_new_d;
      for (int v = 0; v < NVC; v++) state_q[v] <= state_d[v];
    end
  end

  always_comb begin
    for (int v = 0; v < NVC; v++) vc_busy_o[v] = (state_q[v] == BUSY);
  end

  assign vc_val_o = vc_val_q;
  assign vc_new_o = vc_new_q;

`ifdef VC_ALLOC_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = 1'b0;
    for (int v = 0; v < NVC; v++) begin
      if (vc_release_i[v] && state_q[v] == FREE) err_d = 1'b1;
    end
    for (int r = 0; r < NUM_IN; r++) begin
      if (vc_req_i[r] && port_req_i[r*inout_Port +: inout_Port] > WEST) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_allocator.sv
// tb/tb_vc_allocator.sv - table-driven scoreboard bench for vc_allocator
module tb_vc_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vc_req_i;
  logic [29:0] port_req_i;
  logic [9:0]  vc_release_i;
  logic [9:0]  vc_val_o;
  logic [9:0]  vc_new_o;
  logic [9:0]  vc_busy_o;
  logic        err_o;

`ifdef VC_ALLOC_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  vc_allocator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vc_req_i     (vc_req_i),
    .port_req_i   (port_req_i),
    .vc_release_i (vc_release_i),
    .vc_val_o     (vc_val_o),
    .vc_new_o     (vc_new_o),
    .vc_busy_o    (vc_busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  req;
    logic [29:0] port;
    logic [9:0]  rel;
    logic [9:0]  val;
    logic [9:0]  nw;
    logic [9:0]  busy;
    logic        err;
  } vec_t;

  localparam int NROWS = 20;
  vec_t tbl [NROWS];
  vec_t sb [$];
  vec_t e;
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic [9:0] req, logic [2:0] port, logic [9:0] rel,
                              logic [9:0] val, logic [9:0] nw, logic [9:0] busy, logic err);
    vec_t v;
    v.req  = req;
    v.port = {10{port}};
    v.rel  = rel;
    v.val  = val;
    v.nw   = nw;
    v.busy = busy;
    v.err  = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    // req, port, release, exp val, exp new (granted bits only), exp busy, exp err
    tbl[0]  = mk(10'h008, 3'd2, 10'h000, 10'h008, 10'h000, 10'h010, 1'b0);
    tbl[1]  = mk(10'h048, 3'd2, 10'h000, 10'h040, 10'h040, 10'h030, 1'b0);
    tbl[2]  = mk(10'h048, 3'd2, 10'h000, 10'h000, 10'h000, 10'h030, 1'b0);
    tbl[3]  = mk(10'h000, 3'd0, 10'h030, 10'h000, 10'h000, 10'h000, 1'b0);
    tbl[4]  = mk(10'h092, 3'd1, 10'h000, 10'h002, 10'h000, 10'h004, 1'b0);
    tbl[5]  = mk(10'h090, 3'd1, 10'h000, 10'h010, 10'h010, 10'h00C, 1'b0);
    tbl[6]  = mk(10'h080, 3'd1, 10'h000, 10'h000, 10'h000, 10'h00C, 1'b0);
    tbl[7]  = mk(10'h080, 3'd1, 10'h004, 10'h000, 10'h000, 10'h008, 1'b0);
    tbl[8]  = mk(10'h080, 3'd1, 10'h000, 10'h080, 10'h000, 10'h00C, 1'b0);
    tbl[9]  = mk(10'h000, 3'd0, 10'h00C, 10'h000, 10'h000, 10'h000, 1'b0);
    tbl[10] = mk(10'h024, 3'd4, 10'h000, 10'h004, 10'h000, 10'h100, 1'b0);
    tbl[11] = mk(10'h024, 3'd4, 10'h100, 10'h020, 10'h020, 10'h200, 1'b0);
    tbl[12] = mk(10'h024, 3'd4, 10'h200, 10'h004, 10'h000, 10'h100, 1'b0);
    tbl[13] = mk(10'h024, 3'd4, 10'h100, 10'h020, 10'h020, 10'h200, 1'b0);
    tbl[14] = mk(10'h000, 3'd0, 10'h200, 10'h000, 10'h000, 10'h000, 1'b0);
    tbl[15] = mk(10'h201, 3'd0, 10'h000, 10'h201, 10'h000, 10'h041, 1'b0);
    tbl[15].port[27 +: 3] = 3'd3;
    tbl[16] = mk(10'h000, 3'd0, 10'h041, 10'h000, 10'h000, 10'h000, 1'b0);
    tbl[17] = mk(10'h000, 3'd0, 10'h080, 10'h000, 10'h000, 10'h000, ERR_EXP);
    tbl[18] = mk(10'h010, 3'd6, 10'h000, 10'h000, 10'h000, 10'h000, ERR_EXP);
    tbl[19] = mk(10'h000, 3'd0, 10'h000, 10'h000, 10'h000, 10'h000, 1'b0);

    rst_n        = 1'b0;
    vc_req_i     = '0;
    port_req_i   = '0;
    vc_release_i = '0;
    #3;
    chk("reset_val",  {22'd0, vc_val_o},  32'd0);
    chk("reset_new",  {22'd0, vc_new_o},  32'd0);
    chk("reset_busy", {22'd0, vc_busy_o}, 32'd0);
    chk("reset_err",  {31'd0, err_o},     32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      vc_req_i     = tbl[i].req;
      port_req_i   = tbl[i].port;
      vc_release_i = tbl[i].rel;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d_val", i),  {22'd0, vc_val_o},             {22'd0, e.val});
      chk($sformatf("row%0d_new", i),  {22'd0, vc_new_o & e.val},     {22'd0, e.nw & e.val});
      chk($sformatf("row%0d_busy", i), {22'd0, vc_busy_o},            {22'd0, e.busy});
      chk($sformatf("row%0d_err", i),  {31'd0, err_o},                {31'd0, e.err});
    end

    // Reset arriving in the cycle a grant is showing must wipe it and all VC state.
    vc_req_i     = 10'h100;
    port_req_i   = '0;
    vc_release_i = '0;
    @(posedge clk);
    #1;
    chk("mid_grant_val",  {22'd0, vc_val_o},  32'h100);
    chk("mid_grant_busy", {22'd0, vc_busy_o}, 32'h001);
    rst_n    = 1'b0;
    vc_req_i = '0;
    #1;
    chk("mid_rst_val",  {22'd0, vc_val_o},  32'd0);
    chk("mid_rst_busy", {22'd0, vc_busy_o}, 32'd0);
    chk("mid_rst_new",  {22'd0, vc_new_o},  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_val",  {22'd0, vc_val_o},  32'd0);
    chk("post_rst_busy", {22'd0, vc_busy_o}, 32'd0);

    // LOCAL pointer must be back at 0, so r2 beats r8.
    vc_req_i = 10'h104;
    @(posedge clk);
    #1;
    chk("ptr_reset_val",  {22'd0, vc_val_o},  32'h004);
    chk("ptr_reset_busy", {22'd0, vc_busy_o}, 32'h001);
    vc_req_i = '0;
    @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
